// File: rtl/ahb_sram_pattern_master.sv
// AHB-Lite master: writes SEED+k over NUM_WORDS words, reads them back and counts mismatches.
// Latency: start-to-done is 2*NUM_WORDS+3 cycles with zero wait states; each hready_out low cycle adds one.
// Backpressure: hready_out low holds address, control and write data; an ERROR response aborts the run.
module ahb_sram_pattern_master #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned NUM_WORDS = 8192,
    parameter logic [31:0] SEED      = 32'h0000_0000
) (
    input  logic        hclk,
    input  logic        hrst_n,
    input  logic        start,
    output logic        hsel,
    output logic [1:0]  htrans,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic        hwrite,
    output logic [31:0] haddr,
    output logic [31:0] hwdata,
    output logic        hready,
    input  logic [31:0] hrdata,
    input  logic        hready_out,
    input  logic [1:0]  hresp,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_cnt,
    output logic [31:0] first_err_addr,
    output logic        bus_err
);
    typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_TAIL, S_RD, S_RD_TAIL, S_DONE} state_t;

    localparam logic [1:0]  TR_IDLE   = 2'b00;
    localparam logic [1:0]  TR_NONSEQ = 2'b10;
    localparam logic [1:0]  TR_SEQ    = 2'b11;
    localparam logic [1:0]  RESP_ERR  = 2'b01;
    localparam logic [15:0] LAST_IDX  = 16'(NUM_WORDS - 1);

    state_t      state;
    logic [15:0] idx;
    logic        dp_vld;
    logic [31:0] dp_addr;
    logic [31:0] dp_exp;
    logic        resp_err;
    logic        in_rd;
    logic        mism;
    logic [15:0] err_cnt_nxt;

    assign hsize  = 3'b010;
    assign hburst = 3'b001;
    assign hready = 1'b1;

    // dp_* track the transfer whose data phase is in flight this cycle
    assign resp_err    = dp_vld && (hresp == RESP_ERR);
    assign in_rd       = (state == S_RD) || (state == S_RD_TAIL);
    assign mism        = in_rd && dp_vld && hready_out && (hrdata != dp_exp);
    assign err_cnt_nxt = (mism && (err_cnt != 16'hFFFF)) ? err_cnt + 16'd1 : err_cnt;

    always_ff @(posedge hclk or negedge hrst_n) begin
        if (!hrst_n) begin
            state          <= S_IDLE;
            hsel           <= 1'b0;
            htrans         <= TR_IDLE;
            hwrite         <= 1'b0;
            haddr          <= 32'h0;
            hwdata         <= 32'h0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= 16'h0;
            first_err_addr <= 32'h0;
            bus_err        <= 1'b0;
            idx            <= 16'h0;
            dp_vld         <= 1'b0;
            dp_addr        <= 32'h0;
            dp_exp         <= 32'h0;
        end else if (resp_err) begin
            state   <= S_DONE;
            hsel    <= 1'b0;
            htrans  <= TR_IDLE;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b0;
            bus_err <= 1'b1;
            dp_vld  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state          <= S_WR;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_cnt        <= 16'h0;
                        first_err_addr <= 32'h0;
                        bus_err        <= 1'b0;
                        busy           <= 1'b1;
                        hsel           <= 1'b1;
                        htrans         <= TR_NONSEQ;
                        hwrite         <= 1'b1;
                        haddr          <= BASE_ADDR;
                        idx            <= 16'h0;
                        dp_vld         <= 1'b0;
                    end
                end
                S_WR: begin
                    if (hready_out) begin
                        dp_vld <= 1'b1;
                        hwdata <= SEED + {16'h0, idx};
                        if (idx == LAST_IDX) begin
                            htrans <= TR_IDLE;
                            state  <= S_WR_TAIL;
                        end else begin
                            idx    <= idx + 16'd1;
                            haddr  <= haddr + 32'd4;
                            htrans <= TR_SEQ;
                        end
                    end
                end
                S_WR_TAIL: begin
                    if (hready_out) begin
                        dp_vld <= 1'b0;
                        htrans <= TR_NONSEQ;
                        hwrite <= 1'b0;
                        haddr  <= BASE_ADDR;
                        idx    <= 16'h0;
                        state  <= S_RD;
                    end
                end
                S_RD: begin
                    if (hready_out) begin
                        err_cnt <= err_cnt_nxt;
                        if (mism && (err_cnt == 16'h0)) begin
                            first_err_addr <= dp_addr;
                        end
                        dp_vld  <= 1'b1;
                        dp_addr <= haddr;
                        dp_exp  <= SEED + {16'h0, idx};
                        if (idx == LAST_IDX) begin
                            htrans <= TR_IDLE;
                            state  <= S_RD_TAIL;
                        end else begin
                            idx    <= idx + 16'd1;
                            haddr  <= haddr + 32'd4;
                            htrans <= TR_SEQ;
                        end
                    end
                end
                S_RD_TAIL: begin
                    if (hready_out) begin
                        err_cnt <= err_cnt_nxt;
                        if (mism && (err_cnt == 16'h0)) begin
                            first_err_addr <= dp_addr;
                        end
                        dp_vld <= 1'b0;
                        hsel   <= 1'b0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        pass   <= (err_cnt_nxt == 16'h0) && !bus_err;
                        state  <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
